// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz stimulus sequencer and its offline signature checker.
package fuzz_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  // Field placement of the DUT input wires within the packed vector
  localparam int unsigned WIRE0_OFF = 0;
  localparam int unsigned WIRE0_W   = 19;
  localparam int unsigned WIRE1_OFF = 19;
  localparam int unsigned WIRE1_W   = 21;
  localparam int unsigned WIRE2_OFF = 40;
  localparam int unsigned WIRE2_W   = 9;
  localparam int unsigned WIRE3_OFF = 49;
  localparam int unsigned WIRE3_W   = 15;

endpackage

// File: rtl/fuzz_misr32.sv
// Combinational fold of an OUT_W-bit sample into 32 bits followed by one MISR step.
module fuzz_misr32
  import fuzz_seq_pkg::*;
#(
  parameter int unsigned OUT_W = 242
) (
  input  logic [31:0]      sig_i,
  input  logic [OUT_W-1:0] y_i,
  output logic [31:0]      sig_o
);

  localparam int unsigned NCH = (OUT_W + 31) / 32;

  logic [NCH*32-1:0] padded;
  logic [31:0]       folded;

  always_comb begin
    padded              = '0;
    padded[OUT_W-1:0]   = y_i;
    folded              = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      folded = folded ^ padded[k*32 +: 32];
    end
    sig_o = {sig_i[30:0], 1'b0} ^ (sig_i[31] ? MISR_POLY : '0) ^ folded;
  end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Streams packed vectors onto the fuzz DUT inputs, samples y after a settle time and compresses it into a MISR.
module fuzz_stim_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned OUT_W   = 242,
  parameter int unsigned NUM_VEC = 21,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             vec_valid,
  input  logic [IN_W-1:0]  vec_data,
  output logic             vec_ready,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_y,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  output logic [CNT_W-1:0] vec_count,
  output logic [31:0]      signature,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (NUM_VEC < 1 || NUM_VEC > (2 ** CNT_W) - 1) begin : g_bad_num_vec
    $error("fuzz_stim_sequencer: NUM_VEC out of range");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("fuzz_stim_sequencer: SETTLE must be >= 1");
  end
  if (WIRE3_OFF + WIRE3_W != IN_W || WIRE2_OFF + WIRE2_W != WIRE3_OFF ||
      WIRE1_OFF + WIRE1_W != WIRE2_OFF || WIRE0_OFF + WIRE0_W != WIRE1_OFF) begin : g_bad_layout
    $error("fuzz_stim_sequencer: IN_W does not match the wire field layout");
  end

  seq_state_e       state_q, state_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] cap_data_q, cap_data_d;
  logic             cap_valid_q, cap_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      sig_q, sig_d, sig_next;
  logic [SW-1:0]    settle_q, settle_d;

  fuzz_misr32 #(.OUT_W(OUT_W)) u_misr (
    .sig_i (sig_q),
    .y_i   (dut_y),
    .sig_o (sig_next)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    dut_in_d    = dut_in_q;
    cap_data_d  = cap_data_q;
    cap_valid_d = 1'b0;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    settle_d    = settle_q;
    // abort masks ready so a simultaneous vector is never consumed
    vec_ready   = (state_q == ST_FETCH) && !abort;

    if (abort) begin
      state_d  = ST_IDLE;
      dut_in_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dut_in_d = '0;
          if (start) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            sig_d   = MISR_SEED;
          end
        end
        ST_FETCH: begin
          if (vec_valid) begin
            dut_in_d = vec_data;
            settle_d = SW'(SETTLE - 1);
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            cap_data_d  = dut_y;
            cap_valid_d = 1'b1;
            sig_d       = sig_next;
            cnt_d       = cnt_inc;
            state_d     = (cnt_inc == CNT_W'(NUM_VEC)) ? ST_DONE : ST_FETCH;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            sig_d   = MISR_SEED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dut_in_q    <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cnt_q       <= '0;
      sig_q       <= MISR_SEED;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      dut_in_q    <= dut_in_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      settle_q    <= settle_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign cap_data  = cap_data_q;
  assign cap_valid = cap_valid_q;
  assign vec_count = cnt_q;
  assign signature = sig_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_SETTLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer with a stub DUT whose y encodes dut_in and a cycle stamp.
module tb_fuzz_stim_sequencer;

  localparam int unsigned IN_W    = 64;
  localparam int unsigned OUT_W   = 242;
  localparam int unsigned NUM_VEC = 3;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             vec_valid;
  logic [IN_W-1:0]  vec_data;
  logic             vec_ready;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_y;
  logic             cap_valid;
  logic [OUT_W-1:0] cap_data;
  logic [CNT_W-1:0] vec_count;
  logic [31:0]      signature;
  logic             busy;
  logic             done;

  logic [31:0] cyc = '0;
  logic        y_zero;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_sig;
  logic [15:0] exp_cnt;
  logic [IN_W-1:0] last_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub DUT: y changes every cycle so the sampling instant is visible in the capture
  assign dut_y = y_zero ? '0 : {162'b0, cyc[15:0], dut_in};

  fuzz_stim_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
    .dut_in(dut_in), .dut_y(dut_y), .cap_valid(cap_valid), .cap_data(cap_data),
    .vec_count(vec_count), .signature(signature), .busy(busy), .done(done)
  );

  function automatic logic [31:0] fold_m(input logic [OUT_W-1:0] y);
    logic [31:0] f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(input logic [IN_W-1:0] v);
    logic [31:0]      ca;
    logic [15:0]      stamp;
    logic [OUT_W-1:0] ey;
    vec_valid = 1'b1;
    vec_data  = v;
    tick;
    vec_valid = 1'b0;
    vec_data  = ~v;
    check("accept_dut_in", dut_in, v);
    check("settle_ready0", vec_ready, 1'b0);
    check("settle_cap0", cap_valid, 1'b0);
    ca = cyc;
    tick;
    check("settle_ready0b", vec_ready, 1'b0);
    check("settle_cap0b", cap_valid, 1'b0);
    stamp   = ca[15:0] + 16'd1;
    ey      = y_zero ? '0 : {162'b0, stamp, v};
    exp_sig = misr_m(exp_sig, fold_m(ey));
    exp_cnt = exp_cnt + 16'd1;
    tick;
    check("cap_valid", cap_valid, 1'b1);
    check("cap_data", cap_data, ey);
    check("vec_count", vec_count, exp_cnt);
    check("signature", signature, exp_sig);
    last_v = v;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
    vec_data = '0; y_zero = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dut_in", dut_in, '0);
    check("rst_sig", signature, 32'hFFFFFFFF);
    check("rst_cnt", vec_count, '0);
    check("rst_flags", {busy, done, vec_ready, cap_valid}, 4'b0000);
    check("rst_cap_data", cap_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Run 1 with backpressure, first sample all-zero
    pulse_start;
    exp_sig = 32'hFFFFFFFF; exp_cnt = '0;
    check("start_busy", {busy, done, vec_ready}, 3'b101);
    check("start_sig", signature, 32'hFFFFFFFF);
    check("start_cnt", vec_count, '0);
    tick; tick;
    check("wait_ready", vec_ready, 1'b1);
    check("wait_dut_in", dut_in, '0);
    do_vec(64'h1);
    check("first_sig_const", signature, 32'hFB3EE249);
    y_zero = 1'b0;
    tick;
    check("cap_pulse_once", cap_valid, 1'b0);
    do_vec(64'hDEAD_BEEF_0123_4567);
    do_vec(64'h8000_0000_0000_00FF);
    check("done_flags", {busy, done, vec_ready}, 3'b010);
    tick; tick;
    check("done_sig_frozen", signature, exp_sig);
    check("done_cnt_frozen", vec_count, 16'd3);
    check("done_dut_in", dut_in, last_v);
    check("done_cap_low", cap_valid, 1'b0);

    // Restart from DONE, then start while busy
    pulse_start;
    exp_sig = 32'hFFFFFFFF; exp_cnt = '0;
    check("restart_flags", {busy, done}, 2'b10);
    check("restart_sig", signature, 32'hFFFFFFFF);
    check("restart_cnt", vec_count, '0);
    do_vec(64'h0F0F_F0F0_5A5A_A5A5);
    pulse_start;
    check("busy_start_state", {busy, vec_ready}, 2'b11);
    check("busy_start_cnt", vec_count, exp_cnt);
    check("busy_start_sig", signature, exp_sig);

    // Abort in FETCH together with vec_valid
    vec_valid = 1'b1; abort = 1'b1; vec_data = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("abort_ready", vec_ready, 1'b0);
    tick;
    vec_valid = 1'b0; abort = 1'b0;
    check("abort_flags", {busy, done, cap_valid}, 3'b000);
    check("abort_dut_in", dut_in, '0);
    check("abort_cnt_kept", vec_count, 16'd1);
    check("abort_sig_kept", signature, exp_sig);
    tick;
    check("abort_idle", {busy, vec_ready}, 2'b00);

    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 1'b0);

    pulse_start;
    exp_sig = 32'hFFFFFFFF; exp_cnt = '0;
    check("new_start_cnt", vec_count, '0);
    check("new_start_sig", signature, 32'hFFFFFFFF);

    // Async reset while in SETTLE
    vec_valid = 1'b1; vec_data = 64'hCAFE_0000_0000_BEEF;
    tick;
    vec_valid = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {busy, done, vec_ready, cap_valid}, 4'b0000);
    check("mid_rst_dut_in", dut_in, '0);
    check("mid_rst_sig", signature, 32'hFFFFFFFF);
    check("mid_rst_cap_data", cap_data, '0);
    #2 rst_n = 1'b1;
    tick;
    check("post_rst_idle", busy, 1'b0);
    pulse_start;
    exp_sig = 32'hFFFFFFFF; exp_cnt = '0;
    do_vec(64'h1234_5678_9ABC_DEF0);
    check("post_rst_busy", busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fuzz_stim_sequencer.md
Name: fuzz_stim_sequencer

Overview:
- Sequences the fuzz-generated `top` DUT in simulation and on FPGA.
- Accepts packed input vectors over a valid/ready stream and drives them onto the DUT inputs, one vector per step.
- After each vector it waits a programmable settle time, then samples the DUT output `y` and compresses it into a 32-bit MISR signature.
- Signatures from the pre- and post-synthesis netlists are compared directly, replacing per-cycle `$strobe` dumps.

Parameters:
- IN_W, 64, packed DUT input width: {wire3[14:0], wire2[8:0], wire1[20:0], wire0[18:0]}.
- OUT_W, 242, DUT output `y` width.
- NUM_VEC, 21, number of vectors per run; must be >= 1.
- SETTLE, 1, cycles each vector is held before `y` is sampled; must be >= 1.
- CNT_W, 16, width of the vector counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a run; ignored while busy.
- abort  in  1  synchronous abort; returns the block to IDLE.
- vec_valid  in  1  a vector is available on vec_data.
- vec_data  in  IN_W  packed stimulus vector.
- vec_ready  out  1  block can accept a vector this cycle.
- dut_in  out  IN_W  registered drive to the DUT inputs; bits [63:49]=wire3, [48:40]=wire2, [39:19]=wire1, [18:0]=wire0.
- dut_y  in  OUT_W  DUT output `y`.
- cap_valid  out  1  one-cycle pulse: cap_data holds a new sample.
- cap_data  out  OUT_W  registered copy of the last sampled dut_y.
- vec_count  out  CNT_W  number of vectors captured in the current run.
- signature  out  32  MISR state.
- busy  out  1  high in FETCH and SETTLE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, dut_in=0, cap_data=0, cap_valid=0, vec_count=0;
  - signature=SEED (32'hFFFFFFFF), settle counter=0;
  - busy=0, done=0, vec_ready=0.
- States: IDLE, FETCH, SETTLE, DONE.
- IDLE:
  - dut_in is held at 0, matching the all-zero initial vector the DUT sees.
  - On start: go to FETCH; clear vec_count to 0; load signature=SEED.
- FETCH:
  - vec_ready=1 (decoded from the state register).
  - On vec_valid && vec_ready at edge t: dut_in<=vec_data, settle counter<=SETTLE-1, go to SETTLE.
  - Without vec_valid the block waits indefinitely; dut_in keeps its previous value.
- SETTLE:
  - vec_ready=0. The state lasts exactly SETTLE cycles.
  - At edge t+SETTLE (counter==0):
    - cap_data<=dut_y; cap_valid<=1 for exactly one cycle;
    - signature<=misr_step(signature, fold(dut_y)); vec_count<=vec_count+1;
    - next state is DONE if vec_count+1==NUM_VEC, otherwise FETCH.
  - Minimum period per vector is SETTLE+1 cycles.
- DONE:
  - done=1; signature and vec_count are frozen; dut_in holds the last vector.
  - start in DONE restarts the run exactly as from IDLE.
- fold(y):
  - Zero-pad y to a multiple of 32 bits (256 for OUT_W=242) and XOR all 32-bit chunks together.
  - Chunk 0 is y[31:0].
- misr_step(s,d) = ({s[30:0],1'b0} ^ (s[31] ? POLY : 0)) ^ d, with POLY=32'h04C11DB7.
- abort:
  - Takes priority over every other event in any state: next state IDLE, dut_in<=0, cap_valid<=0.
  - signature and vec_count are retained for debug.
  - If abort arrives in the same cycle as vec_valid in FETCH, the vector is not consumed: vec_ready is forced to 0 when abort=1.
- start while busy: ignored. Simultaneous start and abort in IDLE or DONE: abort wins and the block stays in IDLE.
- vec_count wraps modulo 2^CNT_W. NUM_VEC must not exceed 2^CNT_W-1; enforced by an elaboration-time assertion.
- rst_n asserted mid-run: immediate return to reset values; the partial signature is lost.

Decomposition:
- Shared package fuzz_seq_pkg holds:
  - state enum (IDLE, FETCH, SETTLE, DONE);
  - MISR_POLY=32'h04C11DB7 and MISR_SEED=32'hFFFFFFFF;
  - field offset/width constants for wire0..wire3 within dut_in.
- Sub-module fuzz_misr32 (parameter OUT_W) contains the fold and one MISR step, purely combinational.
  - It is shared with the offline signature-compare checker.

Test Plan:
- Reset and single run: NUM_VEC=1, SETTLE=1, DUT stubbed so dut_y=0, one vector 64'h1 → dut_in=64'h1 after accept; cap_valid pulses once, 1 cycle after accept; signature=32'hFB3EE249; vec_count=1; done=1.
- Full run: NUM_VEC=21, SETTLE=1, the team's standard 21-vector fuzz set with vec_valid held high → one vector accepted every 2 cycles; done 42 cycles after start; signature equals the software model over the behavioural `top`.
- Backpressure and settle: SETTLE=3, vec_valid toggled randomly → vec_ready is never high in SETTLE; dut_y is sampled exactly 3 cycles after each accept; signature is identical to the no-gap run.
- Abort in FETCH with simultaneous vec_valid → vector not consumed; IDLE next cycle; dut_in=0; cap_valid=0; vec_count retained. A new start clears vec_count to 0 and reloads the seed.
- Async reset mid-SETTLE: drop rst_n between edges → all outputs at reset values immediately, without waiting for a clock edge; start after release runs normally.
- Restart from DONE: start in DONE → signature reloads 32'hFFFFFFFF, vec_count=0, busy=1 next cycle. A start pulse while busy is ignored (state, vec_count and signature unchanged).
